// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demux.
package demux_pkg;

    localparam int N_MAX = 32;

    function automatic logic sel_in_range(input logic [31:0] s, input int n);
        return s < 32'(n);
    endfunction

    // Low bit of channel k inside the packed F bus.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
module demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // A load wins over a drain, so a draining slot refills in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demux with per-channel handshake and broadcast.
module demux_stream_1ton
    import demux_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            En,
    input  logic [W-1:0]    i,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [SELW-1:0] S,
    input  logic            bcast,
    output logic [N*W-1:0]  F,
    output logic [N-1:0]    F_valid,
    input  logic [N-1:0]    F_ready,
    output logic            err
);

    logic [N-1:0] free;
    logic [N-1:0] sel_oh;
    logic [N-1:0] load;
    logic         in_range;
    logic         accept;

    assign free     = ~F_valid | F_ready;
    assign in_range = sel_in_range(32'(S), N);

    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < N; k++) begin
            sel_oh[k] = (32'(S) == 32'(k));
        end
    end

    // Out-of-range words are swallowed so they never stall the producer.
    always_comb begin
        i_ready = 1'b0;
        if (En) begin
            if (bcast) begin
                i_ready = &free;
            end else if (in_range) begin
                i_ready = |(sel_oh & free);
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    assign accept = i_valid & i_ready;
    assign load   = !accept ? '0 : (bcast ? '1 : sel_oh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= accept & ~bcast & ~in_range;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        logic [W-1:0] q_k;

        demux_slot #(.W(W)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .drain (F_ready[k]),
            .d     (i),
            .q     (q_k),
            .valid (F_valid[k])
        );

        assign F[slice_lo(k, W) +: W] = q_k;
    end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Self-checking bench: directed scenarios plus a random run against a model.
module tb_demux_stream_1ton;

    logic        clk = 1'b0;
    logic        rst;
    logic        En;
    logic        i_valid;
    logic        bcast;
    logic [7:0]  i;
    logic [2:0]  S;
    logic [7:0]  F_ready;

    logic        rdy8, err8;
    logic [63:0] F8;
    logic [7:0]  Fv8;
    logic        rdy6, err6;
    logic [47:0] F6;
    logic [5:0]  Fv6;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_stream_1ton #(.N(8), .W(8)) u8 (
        .clk(clk), .rst(rst), .En(En), .i(i), .i_valid(i_valid),
        .i_ready(rdy8), .S(S), .bcast(bcast), .F(F8),
        .F_valid(Fv8), .F_ready(F_ready), .err(err8)
    );

    demux_stream_1ton #(.N(6), .W(8)) u6 (
        .clk(clk), .rst(rst), .En(En), .i(i), .i_valid(i_valid),
        .i_ready(rdy6), .S(S), .bcast(bcast), .F(F6),
        .F_valid(Fv6), .F_ready(F_ready[5:0]), .err(err6)
    );

    // Reference model: index 0 is the N=8 instance, index 1 the N=6 one.
    int         nch[2] = '{8, 6};
    bit         mv[2][8];
    logic [7:0] md[2][8];
    bit         merr[2];

    logic       act_rdy[2];
    logic       act_err[2];
    logic       act_v[2][8];
    logic [7:0] act_d[2][8];

    always_comb begin
        act_rdy[0] = rdy8;
        act_rdy[1] = rdy6;
        act_err[0] = err8;
        act_err[1] = err6;
        for (int k = 0; k < 8; k++) begin
            act_v[1][k] = 1'b0;
            act_d[1][k] = 8'h00;
            act_v[0][k] = Fv8[k];
            act_d[0][k] = F8[k*8 +: 8];
        end
        for (int k = 0; k < 6; k++) begin
            act_v[1][k] = Fv6[k];
            act_d[1][k] = F6[k*8 +: 8];
        end
    end

    function automatic bit exp_ready(input int m);
        bit r;
        if (!En) return 1'b0;
        if (bcast) begin
            r = 1'b1;
            for (int k = 0; k < nch[m]; k++) r &= (!mv[m][k] || F_ready[k]);
            return r;
        end
        if (int'(S) < nch[m]) return !mv[m][S] || F_ready[S];
        return 1'b1;
    endfunction

    task automatic model_reset;
        for (int m = 0; m < 2; m++) begin
            merr[m] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                mv[m][k] = 1'b0;
                md[m][k] = 8'h00;
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        En = 1'b1; i_valid = 1'b0; bcast = 1'b0;
        i = 8'h00; S = 3'd0; F_ready = 8'hFF;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        En = 1'b0; i_valid = 1'b0; bcast = 1'b0;
        i = 8'h00; S = 3'd0; F_ready = 8'h00;
        #1;
        checks++;
        if ({Fv8, F8, err8} !== 73'd0) begin
            failures++;
            $display("FAIL reset_n8 got v=%h F=%h err=%b exp all 0", Fv8, F8, err8);
        end
        checks++;
        if ({Fv6, F6, err6} !== 55'd0) begin
            failures++;
            $display("FAIL reset_n6 got v=%h F=%h err=%b exp all 0", Fv6, F6, err6);
        end
        checks++;
        if (rdy8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", rdy8);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_disabled;
        En = 1'b0; i_valid = 1'b1; S = 3'd3; i = 8'hA5; F_ready = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (rdy8 !== 1'b0) begin
                failures++;
                $display("FAIL disabled_ready cyc=%0d got=%b exp=0", c, rdy8);
            end
            tick();
            checks++;
            if (Fv8 !== 8'h00) begin
                failures++;
                $display("FAIL disabled_valid cyc=%0d got=%h exp=00", c, Fv8);
            end
        end
        idle_inputs();
    endtask

    task automatic test_sweep;
        En = 1'b1; F_ready = 8'hFF; bcast = 1'b0;
        for (int s = 0; s < 8; s++) begin
            i_valid = 1'b1; S = 3'(s); i = 8'h10 + 8'(s);
            #1;
            checks++;
            if (rdy8 !== 1'b1) begin
                failures++;
                $display("FAIL sweep_ready s=%0d got=%b exp=1", s, rdy8);
            end
            tick();
            checks++;
            if (Fv8 !== 8'(1 << s) || F8[s*8 +: 8] !== 8'h10 + 8'(s)) begin
                failures++;
                $display("FAIL sweep_out s=%0d got v=%h d=%h exp v=%h d=%h",
                         s, Fv8, F8[s*8 +: 8], 8'(1 << s), 8'h10 + 8'(s));
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall;
        F_ready = 8'hFB; i_valid = 1'b1; S = 3'd2; i = 8'h11;
        tick();
        checks++;
        if (Fv8 !== 8'h04 || F8[23:16] !== 8'h11) begin
            failures++;
            $display("FAIL stall_first got v=%h d=%h exp v=04 d=11", Fv8, F8[23:16]);
        end
        i = 8'h22;
        #1;
        checks++;
        if (rdy8 !== 1'b0) begin
            failures++;
            $display("FAIL stall_blocked got=%b exp=0", rdy8);
        end
        tick();
        S = 3'd5; i = 8'h55;
        #1;
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL stall_other_ready got=%b exp=1", rdy8);
        end
        tick();
        checks++;
        if (Fv8 !== 8'h24 || F8[47:40] !== 8'h55 || F8[23:16] !== 8'h11) begin
            failures++;
            $display("FAIL stall_other got v=%h d5=%h d2=%h exp v=24 d5=55 d2=11",
                     Fv8, F8[47:40], F8[23:16]);
        end
        S = 3'd2; i = 8'h22; F_ready = 8'hFF;
        #1;
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_ready got=%b exp=1", rdy8);
        end
        tick();
        checks++;
        if (Fv8 !== 8'h04 || F8[23:16] !== 8'h22) begin
            failures++;
            $display("FAIL stall_second got v=%h d=%h exp v=04 d=22", Fv8, F8[23:16]);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_bcast;
        F_ready = 8'hBF; i_valid = 1'b1; S = 3'd6; i = 8'h66;
        tick();
        bcast = 1'b1; i = 8'h3C;
        #1;
        checks++;
        if (rdy8 !== 1'b0) begin
            failures++;
            $display("FAIL bcast_blocked got=%b exp=0", rdy8);
        end
        tick();
        checks++;
        if (Fv8 !== 8'h40) begin
            failures++;
            $display("FAIL bcast_hold got=%h exp=40", Fv8);
        end
        F_ready = 8'hFF;
        #1;
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL bcast_ready got=%b exp=1", rdy8);
        end
        tick();
        checks++;
        if (Fv8 !== 8'hFF || F8 !== {8{8'h3C}}) begin
            failures++;
            $display("FAIL bcast_out got v=%h F=%h exp v=ff F=%h", Fv8, F8, {8{8'h3C}});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_out_of_range;
        i_valid = 1'b1; S = 3'd7; i = 8'hE7;
        #1;
        checks++;
        if (rdy6 !== 1'b1) begin
            failures++;
            $display("FAIL oor_ready got=%b exp=1", rdy6);
        end
        tick();
        checks++;
        if (err6 !== 1'b1 || Fv6 !== 6'h00) begin
            failures++;
            $display("FAIL oor_first got err=%b v=%h exp err=1 v=00", err6, Fv6);
        end
        S = 3'd6;
        tick();
        checks++;
        if (err6 !== 1'b1 || Fv6 !== 6'h00) begin
            failures++;
            $display("FAIL oor_second got err=%b v=%h exp err=1 v=00", err6, Fv6);
        end
        i_valid = 1'b0;
        tick();
        checks++;
        if (err6 !== 1'b0) begin
            failures++;
            $display("FAIL oor_pulse_end got=%b exp=0", err6);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        F_ready = 8'hEF; i_valid = 1'b1; S = 3'd4; i = 8'h77;
        tick();
        i_valid = 1'b0;
        checks++;
        if (Fv8 !== 8'h10 || F8[39:32] !== 8'h77) begin
            failures++;
            $display("FAIL rstmid_load got v=%h d=%h exp v=10 d=77", Fv8, F8[39:32]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (Fv8 !== 8'h00 || F8 !== 64'd0) begin
            failures++;
            $display("FAIL rstmid_clear got v=%h F=%h exp 0", Fv8, F8);
        end
        tick();
        rst = 1'b0;
        i_valid = 1'b1; S = 3'd4; i = 8'h88;
        #1;
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ready got=%b exp=1", rdy8);
        end
        tick();
        checks++;
        if (Fv8 !== 8'h10 || F8[39:32] !== 8'h88) begin
            failures++;
            $display("FAIL rstmid_reload got v=%h d=%h exp v=10 d=88", Fv8, F8[39:32]);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random;
        bit acc[2];
        bit er[2];
        rst = 1'b1;
        idle_inputs();
        #1 model_reset();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            En      = ($urandom_range(9) != 0);
            i_valid = $urandom_range(1);
            bcast   = ($urandom_range(9) == 0);
            S       = 3'($urandom_range(7));
            i       = 8'($urandom);
            F_ready = 8'($urandom);
            #1;
            for (int m = 0; m < 2; m++) begin
                er[m]  = exp_ready(m);
                acc[m] = i_valid && er[m];
                checks++;
                if (act_rdy[m] !== er[m]) begin
                    failures++;
                    $display("FAIL rand_ready m=%0d cyc=%0d got=%b exp=%b",
                             m, c, act_rdy[m], er[m]);
                end
            end
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < nch[m]; k++) begin
                    if (acc[m] && (bcast || int'(S) == k)) begin
                        mv[m][k] = 1'b1;
                        md[m][k] = i;
                    end else if (mv[m][k] && F_ready[k]) begin
                        mv[m][k] = 1'b0;
                    end
                end
                merr[m] = acc[m] && !bcast && int'(S) >= nch[m];
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (act_err[m] !== merr[m]) begin
                    failures++;
                    $display("FAIL rand_err m=%0d cyc=%0d got=%b exp=%b",
                             m, c, act_err[m], merr[m]);
                end
                for (int k = 0; k < nch[m]; k++) begin
                    checks++;
                    if (act_v[m][k] !== mv[m][k] || act_d[m][k] !== md[m][k]) begin
                        failures++;
                        $display("FAIL rand_slot m=%0d k=%0d cyc=%0d got v=%b d=%h exp v=%b d=%h",
                                 m, k, c, act_v[m][k], act_d[m][k], mv[m][k], md[m][k]);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_disabled();
        test_sweep();
        test_stall();
        test_bcast();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
